age_lru_updater: RTL and testbench
==================================

// Module: age_lru_updater
// PURPOSE
//  Replacement-policy engine that sits in front of the per-set age memory and owns all of its writes.
//  For each cache lookup (set, hit, hit way) it reads the set's age vector and picks the victim on a miss.
//  It then computes the true-LRU update and writes the new vector back, one request per cycle.
//  It also waits out the age memory's post-reset clear sweep and forwards same-set back-to-back updates.
// PARAMETERS
//  C_N_WAY        3  log2(ways); age field width; ways = 1<<C_N_WAY
//  SET_ADDR_WDTH  5  set index width; age memory depth = 1<<SET_ADDR_WDTH
// PORTS
//  clk               in   1                     clock
//  reset             in   1                     reset
//  req_valid_in      in   1                     lookup request valid
//  req_ready_out     out  1                     request accepted when valid&ready
//  req_set_in        in   SET_ADDR_WDTH         set index of request
//  req_hit_in        in   1                     1=hit on req_way_in, 0=miss
//  req_way_in        in   C_N_WAY               hit way (ignored on miss)
//  resp_valid_out    out  1                     1-cycle pulse, result of accepted request
//  resp_way_out      out  C_N_WAY               way touched: hit way, or victim on miss
//  resp_hit_out      out  1                     echo of req_hit_in
//  age_r_addr_out    out  SET_ADDR_WDTH         age memory read address (combinational)
//  age_r_data_in     in   C_N_WAY<<C_N_WAY      age memory read data, registered, 1-cycle latency
//  age_w_addr_out    out  SET_ADDR_WDTH         age memory write address
//  age_w_data_out    out  C_N_WAY<<C_N_WAY      age memory write data
//  age_w_en_out      out  1                     age memory write enable
// BEHAVIOUR
//  - reset: synchronous, active-high, clock clk. Reset values: req_ready_out=0, resp_valid_out=0, age_w_en_out=0.
//    Also on reset: resp_way_out=0, resp_hit_out=0, the stage-1 valid bit=0, and the state goes to INIT.
//  - Age vector layout: way w age = bits [w*C_N_WAY +: C_N_WAY]. Age 0=MRU, (1<<C_N_WAY)-1=LRU.
//    The vector is always a permutation; after memory clear, way w has age 7-w.
//  - FSM INIT: counter runs 0..(1<<SET_ADDR_WDTH)-1 and req_ready_out=0. On the cycle after it reaches max -> RUN.
//  - FSM RUN: req_ready_out=1 (no backpressure). Reset in any state -> INIT.
//  - Stage 0 (accept cycle): age_r_addr_out=req_set_in always; latch set/hit/way into stage 1.
//  - Stage 1 (next cycle): ages = fwd ? last written vector : age_r_data_in.
//    fwd is asserted when stage 1 holds the same set that was written on the previous cycle.
//    The memory reads old data on a same-cycle write, so fwd is mandatory.
//  - Target way k: k=req_way on hit. On miss, k = the way whose age == all-ones; lowest index wins if the vector is corrupt.
//  - Update: a=age[k]; every way with age<a gets +1; age[k]=0; other ways unchanged. Width C_N_WAY, no overflow possible.
//  - Stage 1 outputs in the same cycle: age_w_en_out=1, age_w_addr_out=set, age_w_data_out=new vector,
//    resp_valid_out=1, resp_way_out=k, resp_hit_out=hit.
//  - Hit on an MRU way (a=0) still writes, with an unchanged vector.
//  - Latency: request accepted cycle N -> resp and write in cycle N+1. Throughput 1/cycle, including same set back-to-back.
//  - Idle cycle (no stage-1 valid): age_w_en_out=0, resp_valid_out=0. Other outputs hold their last value.
//  - reset mid-operation: in-flight stage-1 request is dropped. No write, no resp. Re-enter INIT.
// TESTING
//  - Reset then hold req_valid_in=1 -> req_ready_out=0 for exactly 32 cycles, then 1. No write and no resp during INIT.
//  - Fresh set 3, miss -> resp_way_out=0. Write ages way0..7 = {0,7,6,5,4,3,2,1}, 1 cycle after accept.
//  - Fresh set 1, hit way 4 (age 3) -> ways 5,6,7 become 3,2,1, way4=0, ways 0..3 unchanged (7,6,5,4).
//  - Back-to-back misses on set 2 in consecutive cycles -> victims way0 then way1 (forwarded vector).
//    The second write is ages {1,0,7,6,5,4,3,2}.
//  - Alternating sets 5,6,5,6 hits on way 7 -> no forwarding, and each write equals the initial permutation.
//  - Assert reset while a stage-1 request is pending -> no age_w_en_out, resp_valid_out=0, INIT restarts at 32 cycles.

Source files
------------

// File: rtl/age_lru_updater.sv
// age_lru_updater: true-LRU age update engine in front of the per-set age memory
module age_lru_updater #(
  parameter int C_N_WAY       = 3,
  parameter int SET_ADDR_WDTH = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid_in,
  output logic                          req_ready_out,
  input  logic [SET_ADDR_WDTH-1:0]      req_set_in,
  input  logic                          req_hit_in,
  input  logic [C_N_WAY-1:0]            req_way_in,
  output logic                          resp_valid_out,
  output logic [C_N_WAY-1:0]            resp_way_out,
  output logic                          resp_hit_out,
  output logic [SET_ADDR_WDTH-1:0]      age_r_addr_out,
  input  logic [(C_N_WAY<<C_N_WAY)-1:0] age_r_data_in,
  output logic [SET_ADDR_WDTH-1:0]      age_w_addr_out,
  output logic [(C_N_WAY<<C_N_WAY)-1:0] age_w_data_out,
  output logic                          age_w_en_out
);
  localparam int WAYS = 1 << C_N_WAY;
  localparam int VW   = C_N_WAY << C_N_WAY;
  typedef enum logic {INIT, RUN} state_t;
  state_t                   state, state_nx;
  logic [SET_ADDR_WDTH-1:0] cnt;
  logic                     s1_valid, s1_hit;
  logic [SET_ADDR_WDTH-1:0] s1_set;
  logic [C_N_WAY-1:0]       s1_way;
  logic                     wr_prev, hit_q;
  logic [C_N_WAY-1:0]       way_q;
  logic [SET_ADDR_WDTH-1:0] waddr_q;
  logic [VW-1:0]            wdata_q;
  logic                     v1, fwd, accept;
  logic [VW-1:0]            ages, new_ages;
  logic [C_N_WAY-1:0]       victim, k, a;
  assign req_ready_out  = state == RUN;
  assign accept         = req_valid_in & req_ready_out;
  assign age_r_addr_out = req_set_in;
  // A reset arriving while stage 1 is occupied kills that request outright.
  assign v1             = s1_valid & ~reset;
  // The memory returns stale data when read in the same cycle it is written, so replay the last write.
  assign fwd            = wr_prev & (waddr_q == s1_set);
  assign ages           = fwd ? wdata_q : age_r_data_in;
  assign k              = s1_hit ? s1_way : victim;
  assign resp_valid_out = v1;
  assign age_w_en_out   = v1;
  assign resp_way_out   = v1 ? k : way_q;
  assign resp_hit_out   = v1 ? s1_hit : hit_q;
  assign age_w_addr_out = v1 ? s1_set : waddr_q;
  assign age_w_data_out = v1 ? new_ages : wdata_q;
  // State register and clear-sweep counter; the memory clears one set per cycle after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == INIT) ? cnt + 1'b1 : cnt;
    end
  end
  // Leave INIT the cycle after the sweep counter has covered the last set.
  always_comb begin
    state_nx = (state == INIT && &cnt) ? RUN : state;
  end
  // Stage-1 request capture.
  always_ff @(posedge clk) begin
    if (reset) s1_valid <= 1'b0;
    else s1_valid <= accept;
    if (accept) begin
      s1_set <= req_set_in;
      s1_hit <= req_hit_in;
      s1_way <= req_way_in;
    end
  end
  // Last-issued outputs, held through idle cycles and reused as the forwarding source.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_prev <= 1'b0;
      way_q   <= '0;
      hit_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wr_prev <= v1;
      if (v1) begin
        way_q   <= k;
        hit_q   <= s1_hit;
        waddr_q <= s1_set;
        wdata_q <= new_ages;
      end
    end
  end
  // Victim is the oldest way; scanning downward lets the lowest index win on a corrupt vector.
  always_comb begin
    victim = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (ages[w*C_N_WAY +: C_N_WAY] == '1) victim = C_N_WAY'(w);
  end
  // Touched way becomes MRU; everything younger than it ages by one.
  always_comb begin
    a        = '0;
    new_ages = ages;
    for (int w = 0; w < WAYS; w++)
      if (C_N_WAY'(w) == k) a = ages[w*C_N_WAY +: C_N_WAY];
    for (int w = 0; w < WAYS; w++)
      new_ages[w*C_N_WAY +: C_N_WAY] = (C_N_WAY'(w) == k) ? '0 :
        (ages[w*C_N_WAY +: C_N_WAY] < a) ? ages[w*C_N_WAY +: C_N_WAY] + 1'b1 :
        ages[w*C_N_WAY +: C_N_WAY];
  end
endmodule

// File: tb/tb_age_lru_updater.sv
// tb_age_lru_updater: randomized check of the LRU updater against a recency-list model
module tb_age_lru_updater;
  localparam int NW = 3, SW = 5, WAYS = 8, VW = 24, NSET = 32;
  localparam logic [VW-1:0] INIT_VEC = 24'h053977;
  logic clk = 0, reset = 1, req_valid_in = 0, req_hit_in = 0;
  logic [SW-1:0] req_set_in = '0;
  logic [NW-1:0] req_way_in = '0;
  logic req_ready_out, resp_valid_out, resp_hit_out, age_w_en_out;
  logic [NW-1:0] resp_way_out;
  logic [SW-1:0] age_r_addr_out, age_w_addr_out;
  logic [VW-1:0] age_r_data_in = '0, age_w_data_out;
  logic [VW-1:0] mem [NSET];
  int order [NSET][WAYS];
  typedef struct {
    int            due;
    logic [SW-1:0] set;
    logic          hit;
    logic [NW-1:0] way;
    logic [VW-1:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t ce;
  int cyc = 0, n_init = 0, total = 0, passed = 0;
  always #5 clk = ~clk;
  age_lru_updater #(.C_N_WAY(NW), .SET_ADDR_WDTH(SW)) dut (
    .clk(clk), .reset(reset), .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_set_in(req_set_in), .req_hit_in(req_hit_in), .req_way_in(req_way_in),
    .resp_valid_out(resp_valid_out), .resp_way_out(resp_way_out), .resp_hit_out(resp_hit_out),
    .age_r_addr_out(age_r_addr_out), .age_r_data_in(age_r_data_in),
    .age_w_addr_out(age_w_addr_out), .age_w_data_out(age_w_data_out), .age_w_en_out(age_w_en_out)
  );
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    n_init <= reset ? 0 : (n_init < 32 ? n_init + 1 : n_init);
    if (reset) for (int i = 0; i < NSET; i++) mem[i] <= INIT_VEC;
    else if (age_w_en_out) mem[age_w_addr_out] <= age_w_data_out;
    age_r_data_in <= mem[age_r_addr_out];
  end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask
  function automatic logic [VW-1:0] vec_of(int s);
    logic [VW-1:0] v;
    v = '0;
    for (int p = 0; p < WAYS; p++) v[order[s][p]*NW +: NW] = NW'(p);
    return v;
  endfunction
  task automatic touch(int s, int w);
    int p;
    p = 0;
    while (order[s][p] != w) p++;
    for (int i = p; i > 0; i--) order[s][i] = order[s][i-1];
    order[s][0] = w;
  endtask
  task automatic model_reset();
    for (int s = 0; s < NSET; s++)
      for (int p = 0; p < WAYS; p++) order[s][p] = WAYS - 1 - p;
    exp_q.delete();
  endtask
  task automatic req(int s, bit h, int w);
    exp_t e;
    int k;
    req_valid_in = 1; req_set_in = SW'(s); req_hit_in = h; req_way_in = NW'(w);
    if (n_init == 32 && !reset) begin
      k = h ? w : order[s][WAYS-1];
      touch(s, k);
      e.due = cyc + 1; e.set = SW'(s); e.hit = h; e.way = NW'(k); e.data = vec_of(s);
      exp_q.push_back(e);
    end
  endtask
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic idle(); req_valid_in = 0; endtask
  task automatic lit(string nm, int w, logic [VW-1:0] d);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(resp_valid_out), 1);
    chk({nm, "_way"}, 32'(resp_way_out), 32'(w));
    chk({nm, "_data"}, 32'(age_w_data_out), 32'(d));
  endtask
  task automatic count_init(string nm);
    int zeros;
    zeros = 0;
    req_valid_in = 1; req_set_in = 5'd9; req_hit_in = 0;
    while (!req_ready_out && zeros < 100) begin zeros++; tick(); end
    idle();
    chk(nm, 32'(zeros), 32);
  endtask
  always @(negedge clk) begin
    chk("ready", 32'(req_ready_out), 32'(n_init == 32));
    if (!reset && exp_q.size() > 0 && exp_q[0].due == cyc) begin
      ce = exp_q.pop_front();
      chk("resp_valid", 32'(resp_valid_out), 1);
      chk("w_en", 32'(age_w_en_out), 1);
      chk("resp_way", 32'(resp_way_out), 32'(ce.way));
      chk("resp_hit", 32'(resp_hit_out), 32'(ce.hit));
      chk("w_addr", 32'(age_w_addr_out), 32'(ce.set));
      chk("w_data", 32'(age_w_data_out), 32'(ce.data));
    end else begin
      chk("idle_resp_valid", 32'(resp_valid_out), 0);
      chk("idle_w_en", 32'(age_w_en_out), 0);
    end
  end
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    count_init("init_len");
    req(3, 0, 0); tick(); idle(); lit("set3_miss", 0, 24'h29CBB8); tick();
    req(1, 1, 4); tick(); idle(); lit("set1_hit4", 4, 24'h298977); tick();
    req(2, 0, 0); tick(); req(2, 0, 0); lit("b2b_a", 0, 24'h29CBB8);
    tick(); idle(); lit("b2b_b", 1, 24'h4E5DC1); tick();
    for (int i = 0; i < 4; i++) begin
      req(i % 2 ? 6 : 5, 1, 7); tick(); lit("alt", 7, INIT_VEC);
    end
    idle(); tick();
    repeat (3000) begin
      if ($urandom_range(0, 9) < 8)
        req(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      else idle();
      tick();
    end
    idle(); tick();
    req(4, 0, 0); tick();
    reset = 1; idle(); model_reset();
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid_out), 0);
    chk("rst_w_en", 32'(age_w_en_out), 0);
    tick(); tick();
    reset = 0;
    count_init("reinit_len");
    req(3, 0, 0); tick(); idle(); lit("post_rst_miss", 0, 24'h29CBB8); tick();
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
